down_counter_nbit: RTL and testbench

- Loadable N-bit down-counter; the decrementing counterpart of the team's loadable up-counter.
- Decrements on `en` and flags underflow with a borrow-out (`bo`).
- A small FSM tracks one loaded countdown and pulses `done` when it expires.
- Used as a loop/iteration terminator and timeout counter in datapath controllers.

---
 rtl/down_counter_nbit_pkg.sv | 18 +
 rtl/down_counter_nbit_subtractor.sv | 22 ++
 rtl/down_counter_nbit.sv | 93 +++++++++
 tb/tb_down_counter_nbit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/down_counter_nbit_pkg.sv
// Shared definitions for the loadable down-counter: FSM state encodings and default width.
// Used by down_counter_nbit; see that file for the DOWN_COUNTER_AUTO_RELOAD_EN option.
package down_counter_nbit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_EXPIRE = 2'b10
  } state_t;

  // State entered on a load: a nonzero value starts a countdown, zero expires at once.
  function automatic state_t load_state(input logic nonzero);
    return nonzero ? ST_RUN : ST_EXPIRE;
  endfunction

endpackage

// File: rtl/down_counter_nbit_subtractor.sv
// Ripple-style N-bit subtractor with borrow-in/borrow-out: out = in1 - in2 - bin.
// bo is high when the true difference is negative.
module subtractor
  import down_counter_nbit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic [WIDTH-1:0] out,
  output logic             bo
);

  logic [WIDTH:0] diff;

  // Zero-extend one bit so the MSB of the difference is the borrow.
  assign diff = {1'b0, in1} - {1'b0, in2} - (WIDTH+1)'(bin);
  assign out  = diff[WIDTH-1:0];
  assign bo   = diff[WIDTH];

endmodule

// File: rtl/down_counter_nbit.sv
// Loadable N-bit down-counter with borrow-out and a countdown-tracking FSM (IDLE/RUN/EXPIRE).
// Optional DOWN_COUNTER_AUTO_RELOAD_EN: reload the last loaded value on underflow (periodic mode).
module down_counter_nbit
  import down_counter_nbit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] count,
  output logic             bo,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] count_nxt;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  // count - en; borrow is en & (count == 0).
  subtractor #(
    .WIDTH(WIDTH)
  ) u_subtractor (
    .in1 (count),
    .in2 ('0),
    .bin (en),
    .out (diff),
    .bo  (borrow)
  );

  assign bo   = borrow & ~load;
  assign zero = (count == '0);
  assign busy = (state == ST_RUN);
  assign done = (state == ST_EXPIRE);

  // Count update priority: load, then decrement (or reload on underflow), else hold.
  always_comb begin
    count_nxt = diff;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    if (borrow) begin
      count_nxt = reload;
    end
`endif
    if (load) begin
      count_nxt = in;
    end
  end

  // Count register and FSM. EXPIRE decides its next state as IDLE would, since IDLE is its successor.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      state <= ST_IDLE;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      count <= count_nxt;
      if (load) begin
        state <= load_state(in != '0);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload <= in;
`endif
      end else begin
        case (state)
          ST_IDLE, ST_EXPIRE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            state <= (borrow && (reload != '0)) ? ST_RUN : ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end
          ST_RUN: begin
            if (en && (count == WIDTH'(1))) begin
              state <= ST_EXPIRE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_counter_nbit.sv
// Directed self-checking bench for down_counter_nbit at WIDTH = 3.
// The periodic-mode section is compiled only with DOWN_COUNTER_AUTO_RELOAD_EN.
module tb_down_counter_nbit;

  localparam int unsigned W = 3;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] in;
  logic [W-1:0] count;
  logic         bo;
  logic         zero;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_mis;

  down_counter_nbit #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .in    (in),
    .count (count),
    .bo    (bo),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic e, input logic [W-1:0] v);
    load = l;
    en   = e;
    in   = v;
    #1;
  endtask

  task automatic expect_q(input string tag, input logic [W-1:0] c, input logic b, input logic d);
    check({tag, ".count"}, 16'(count), 16'(c));
    check({tag, ".busy"},  16'(busy),  16'(b));
    check({tag, ".done"},  16'(done),  16'(d));
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;

    // Reset held two cycles while load and en are asserted.
    rst = 1'b1;
    drive(1'b1, 1'b1, 3'd5);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0);
    expect_q("reset", 3'd0, 1'b0, 1'b0);
    check("reset.zero", 16'(zero), 16'd1);
    check("reset.bo", 16'(bo), 16'd0);

    // Countdown 3, 2, 1, 0 with done on the cycle count reads 0.
    drive(1'b1, 1'b0, 3'd3);
    tick();
    drive(1'b0, 1'b1, 3'd0);
    expect_q("cd3", 3'd3, 1'b1, 1'b0);
    check("cd3.bo", 16'(bo), 16'd0);
    tick();
    expect_q("cd2", 3'd2, 1'b1, 1'b0);
    tick();
    expect_q("cd1", 3'd1, 1'b1, 1'b0);
    check("cd1.bo", 16'(bo), 16'd0);
    tick();
    drive(1'b0, 1'b0, 3'd0);
    expect_q("cd0", 3'd0, 1'b0, 1'b1);
    check("cd0.zero", 16'(zero), 16'd1);
    check("cd0.bo", 16'(bo), 16'd0);
    tick();
    expect_q("cd_after", 3'd0, 1'b0, 1'b0);

    // Zero load expires immediately without entering RUN.
    drive(1'b1, 1'b0, 3'd0);
    tick();
    drive(1'b0, 1'b0, 3'd0);
    expect_q("zload", 3'd0, 1'b0, 1'b1);
    tick();
    expect_q("zload_after", 3'd0, 1'b0, 1'b0);

    // Free-running wrap from 0 in IDLE.
    drive(1'b0, 1'b1, 3'd0);
    check("wrap.bo", 16'(bo), 16'd1);
    tick();
    expect_q("wrap", 3'd7, 1'b0, 1'b0);
    check("wrap.bo_after", 16'(bo), 16'd0);
    check("wrap.zero", 16'(zero), 16'd0);
    tick();
    expect_q("idle_dec", 3'd6, 1'b0, 1'b0);

    // Load beats en mid-countdown and restarts without a done pulse.
    drive(1'b1, 1'b0, 3'd4);
    tick();
    drive(1'b0, 1'b1, 3'd0);
    tick();
    tick();
    expect_q("pre_restart", 3'd2, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 3'd5);
    tick();
    drive(1'b0, 1'b0, 3'd0);
    expect_q("restart", 3'd5, 1'b1, 1'b0);
    tick();
    tick();
    expect_q("hold", 3'd5, 1'b1, 1'b0);

    // Reset mid-run.
    drive(1'b1, 1'b0, 3'd6);
    tick();
    drive(1'b0, 1'b1, 3'd0);
    tick();
    tick();
    expect_q("pre_rst", 3'd4, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0);
    expect_q("mid_rst", 3'd0, 1'b0, 1'b0);
    tick();
    expect_q("mid_rst_after", 3'd0, 1'b0, 1'b0);

    // Load taken during EXPIRE; load also masks bo at count 0.
    drive(1'b1, 1'b0, 3'd1);
    tick();
    drive(1'b0, 1'b1, 3'd0);
    tick();
    drive(1'b1, 1'b1, 3'd2);
    expect_q("exp_load_pre", 3'd0, 1'b0, 1'b1);
    check("exp_load.bo", 16'(bo), 16'd0);
    tick();
    drive(1'b0, 1'b0, 3'd0);
    expect_q("exp_load", 3'd2, 1'b1, 1'b0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Periodic mode: load 2 then en held -> 2, 1, 0, 2, 1, 0.
    begin
      logic [W-1:0] exp_c [6] = '{3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0};
      logic         exp_d [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      drive(1'b1, 1'b0, 3'd2);
      tick();
      drive(1'b0, 1'b1, 3'd0);
      for (int i = 0; i < 6; i++) begin
        check($sformatf("auto%0d.count", i), 16'(count), 16'(exp_c[i]));
        check($sformatf("auto%0d.done", i), 16'(done), 16'(exp_d[i]));
        check($sformatf("auto%0d.bo", i), 16'(bo), 16'(exp_c[i] == 3'd0));
        tick();
      end
      expect_q("auto_wrap", 3'd2, 1'b1, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
